// File: rtl/dcache_bank_sched_pkg.sv
// Shared dcache bank definitions: line geometry and the
// per-cycle bank grant encoding.
package dcache_bank_sched_pkg;

  localparam int LINE_WORDS    = 8;
  localparam int LINE_BITS     = 256;
  localparam int WORD_OFF_BITS = 3;

  typedef enum logic [1:0] {
    GNT_NONE,
    GNT_REFILL,
    GNT_LOAD,
    GNT_STORE
  } gnt_e;

endpackage

// File: rtl/dcache_store_buf.sv
// One-entry store buffer with starvation counter and load forward match.
// Ports: st_* store in, drain grant, ld_addr match, sb_* contents, force_drain, fwd_ben.
module dcache_store_buf
  import dcache_bank_sched_pkg::*;
#(
  parameter int ADDR_WIDTH   = 10,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  st_valid,
  input  logic [ADDR_WIDTH-1:0] st_addr,
  input  logic [31:0]           st_wdata,
  input  logic [3:0]            st_ben,
  input  logic                  drain,
  input  logic [ADDR_WIDTH-1:0] ld_addr,
  output logic                  st_ready,
  output logic                  sb_valid,
  output logic [ADDR_WIDTH-1:0] sb_addr,
  output logic [31:0]           sb_data,
  output logic [3:0]            sb_ben,
  output logic                  force_drain,
  output logic [3:0]            fwd_ben
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic [3:0] starve_cnt;
  logic       accept;

  assign st_ready    = resetn && (!sb_valid || drain);
  assign accept      = st_valid && st_ready;
  assign force_drain = sb_valid && (starve_cnt == LIMIT);
  assign fwd_ben     = (sb_valid && sb_addr == ld_addr) ? sb_ben : 4'h0;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sb_valid   <= 1'b0;
      sb_addr    <= '0;
      sb_data    <= '0;
      sb_ben     <= '0;
      starve_cnt <= '0;
    end else begin
      if (accept) begin
        sb_valid <= 1'b1;
        sb_addr  <= st_addr;
        sb_data  <= st_wdata;
        sb_ben   <= st_ben;
      end else if (drain) begin
        sb_valid <= 1'b0;
      end
      // Saturate at the limit so a refill burst cannot push the
      // counter past the forcing threshold.
      if (!sb_valid || drain)
        starve_cnt <= '0;
      else if (starve_cnt != LIMIT)
        starve_cnt <= starve_cnt + 4'd1;
    end
  end

endmodule

// File: rtl/dcache_bank_sched.sv
// Single-port dcache data bank scheduler: refill > forced store > load > store.
// Ports: ld_* load req/resp, st_* store req, rf_* refill req, bram_* bank port.
module dcache_bank_sched
  import dcache_bank_sched_pkg::*;
#(
  parameter int ADDR_WIDTH   = 10,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  ld_valid,
  input  logic [ADDR_WIDTH-1:0] ld_addr,
  output logic                  ld_ready,
  output logic                  ld_rvalid,
  output logic [31:0]           ld_rdata,
  input  logic                  st_valid,
  input  logic [ADDR_WIDTH-1:0] st_addr,
  input  logic [31:0]           st_wdata,
  input  logic [3:0]            st_ben,
  output logic                  st_ready,
  input  logic                  rf_valid,
  input  logic [ADDR_WIDTH-1:0] rf_addr,
  input  logic [LINE_BITS-1:0]  rf_data,
  output logic                  rf_ready,
  output logic [ADDR_WIDTH-1:0] bram_raddr,
  output logic                  bram_re,
  output logic [ADDR_WIDTH-1:0] bram_waddr,
  output logic                  bram_we,
  output logic [31:0]           bram_din,
  output logic [LINE_BITS-1:0]  bram_din_all,
  output logic                  bram_hit_write,
  output logic [3:0]            bram_byte_ben,
  output logic                  bram_store,
  input  logic [31:0]           bram_dout
);

  gnt_e                  gnt;
  logic                  sb_valid;
  logic [ADDR_WIDTH-1:0] sb_addr;
  logic [31:0]           sb_data;
  logic [3:0]            sb_ben;
  logic                  force_drain;
  logic [3:0]            fwd_ben;
  logic                  rd_pend;
  logic [3:0]            fwd_ben_q;
  logic [31:0]           fwd_data_q;

  dcache_store_buf #(
    .ADDR_WIDTH  (ADDR_WIDTH),
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_sb (
    .clk        (clk),
    .resetn     (resetn),
    .st_valid   (st_valid),
    .st_addr    (st_addr),
    .st_wdata   (st_wdata),
    .st_ben     (st_ben),
    .drain      (gnt == GNT_STORE),
    .ld_addr    (ld_addr),
    .st_ready   (st_ready),
    .sb_valid   (sb_valid),
    .sb_addr    (sb_addr),
    .sb_data    (sb_data),
    .sb_ben     (sb_ben),
    .force_drain(force_drain),
    .fwd_ben    (fwd_ben)
  );

  always_comb begin
    gnt = GNT_NONE;
    if (!resetn)          gnt = GNT_NONE;
    else if (rf_valid)    gnt = GNT_REFILL;
    else if (force_drain) gnt = GNT_STORE;
    else if (ld_valid)    gnt = GNT_LOAD;
    else if (sb_valid)    gnt = GNT_STORE;
  end

  always_comb begin
    ld_ready       = 1'b0;
    rf_ready       = 1'b0;
    bram_re        = 1'b0;
    bram_raddr     = '0;
    bram_we        = 1'b0;
    bram_waddr     = '0;
    bram_din       = '0;
    bram_din_all   = '0;
    bram_hit_write = 1'b0;
    bram_byte_ben  = '0;
    bram_store     = 1'b0;
    unique case (gnt)
      GNT_REFILL: begin
        rf_ready       = 1'b1;
        bram_we        = 1'b1;
        bram_hit_write = 1'b1;
        bram_waddr     = rf_addr;
        bram_din_all   = rf_data;
      end
      GNT_LOAD: begin
        ld_ready   = 1'b1;
        bram_re    = 1'b1;
        bram_raddr = ld_addr;
      end
      GNT_STORE: begin
        bram_we       = 1'b1;
        bram_store    = 1'b1;
        bram_waddr    = sb_addr;
        bram_din      = sb_data;
        bram_byte_ben = sb_ben;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rd_pend    <= 1'b0;
      fwd_ben_q  <= '0;
      fwd_data_q <= '0;
    end else begin
      rd_pend <= (gnt == GNT_LOAD);
      if (gnt == GNT_LOAD) begin
        fwd_ben_q  <= fwd_ben;
        fwd_data_q <= sb_data;
      end
    end
  end

  assign ld_rvalid = rd_pend;

  // Bank data arrives the cycle after the read; merge buffered bytes over it.
  always_comb begin
    ld_rdata = '0;
    if (rd_pend)
      for (int i = 0; i < 4; i++)
        ld_rdata[8*i +: 8] = fwd_ben_q[i] ? fwd_data_q[8*i +: 8]
                                          : bram_dout[8*i +: 8];
  end

endmodule

// File: tb/tb_dcache_bank_sched.sv
// Self-checking bench for dcache_bank_sched with a bank model
// and a load-response scoreboard.
module tb_dcache_bank_sched;

  localparam int AW = 10;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          ld_valid, ld_ready, ld_rvalid;
  logic [AW-1:0] ld_addr;
  logic [31:0]   ld_rdata;
  logic          st_valid, st_ready;
  logic [AW-1:0] st_addr;
  logic [31:0]   st_wdata;
  logic [3:0]    st_ben;
  logic          rf_valid, rf_ready;
  logic [AW-1:0] rf_addr;
  logic [255:0]  rf_data;
  logic [AW-1:0] bram_raddr, bram_waddr;
  logic          bram_re, bram_we, bram_hit_write, bram_store;
  logic [31:0]   bram_din, bram_dout;
  logic [255:0]  bram_din_all;
  logic [3:0]    bram_byte_ben;

  logic [31:0] mem [0:1023];
  logic [31:0] exp_q [$];
  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  dcache_bank_sched #(.ADDR_WIDTH(AW), .STARVE_LIMIT(4)) dut (
    .clk(clk), .resetn(resetn),
    .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_ready(ld_ready),
    .ld_rvalid(ld_rvalid), .ld_rdata(ld_rdata),
    .st_valid(st_valid), .st_addr(st_addr), .st_wdata(st_wdata),
    .st_ben(st_ben), .st_ready(st_ready),
    .rf_valid(rf_valid), .rf_addr(rf_addr), .rf_data(rf_data),
    .rf_ready(rf_ready),
    .bram_raddr(bram_raddr), .bram_re(bram_re),
    .bram_waddr(bram_waddr), .bram_we(bram_we),
    .bram_din(bram_din), .bram_din_all(bram_din_all),
    .bram_hit_write(bram_hit_write), .bram_byte_ben(bram_byte_ben),
    .bram_store(bram_store), .bram_dout(bram_dout)
  );

  function automatic logic [31:0] pat(int a);
    return 32'h5A00_0000 + 32'(a);
  endfunction

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  // Bank model: 1-cycle read, byte-enabled store, full-line refill.
  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < 1024; i++) mem[i] <= pat(i);
      mem[10'h025] <= 32'h1122_3344;
      mem[10'h026] <= 32'h1234_5678;
      bram_dout    <= '0;
    end else begin
      if (bram_re) bram_dout <= mem[bram_raddr];
      if (bram_we && bram_store) begin
        for (int b = 0; b < 4; b++)
          if (bram_byte_ben[b])
            mem[bram_waddr][8*b +: 8] <= bram_din[8*b +: 8];
      end else if (bram_we && bram_hit_write) begin
        for (int j = 0; j < 8; j++)
          mem[{bram_waddr[AW-1:3], 3'(j)}] <= bram_din_all[32*j +: 32];
      end
    end
  end

  always @(negedge clk) begin
    if (bram_re && bram_we) chk("port_excl", 64'd1, 64'd0);
    if (ld_rvalid) begin
      if (exp_q.size() == 0) chk("rvalid_extra", 64'd1, 64'd0);
      else chk("ld_rdata", 64'(ld_rdata), 64'(exp_q.pop_front()));
    end
  end

  initial begin
    ld_valid = 1'b1; ld_addr = 10'h010;
    st_valid = 1'b1; st_addr = 10'h011; st_wdata = 32'hFFFF_FFFF; st_ben = 4'hF;
    rf_valid = 1'b1; rf_addr = 10'h018;
    for (int j = 0; j < 8; j++) rf_data[32*j +: 32] = 32'hF000_0000 + 32'(j);

    // reset gating with every requester active
    smp();
    chk("rst_ready", {ld_ready, st_ready, rf_ready}, 0);
    chk("rst_bram", {bram_we, bram_re, bram_hit_write, bram_store,
                     bram_byte_ben, bram_raddr, bram_waddr, bram_din}, 0);
    chk("rst_line", bram_din_all[63:0], 0);
    chk("rst_rv", {ld_rvalid, ld_rdata}, 0);
    ld_valid = 0; st_valid = 0; rf_valid = 0;
    cyc();
    resetn = 1'b1;

    // reset mid-load drops the response
    ld_valid = 1; ld_addr = 10'h010;
    smp(); chk("t1_ldrdy", ld_ready, 1);
    cyc(); resetn = 1'b0; ld_valid = 0;
    smp(); chk("t1_rv", ld_rvalid, 0);
    chk("t1_bram", {bram_we, bram_re, bram_waddr, bram_raddr}, 0);
    cyc(); resetn = 1'b1;
    smp(); chk("t1_rv2", ld_rvalid, 0);
    cyc();

    // store then full-forward load
    st_valid = 1; st_addr = 10'h025; st_wdata = 32'hAABB_CCDD; st_ben = 4'hF;
    smp(); chk("t2_strdy", st_ready, 1);
    cyc(); st_valid = 0; ld_valid = 1; ld_addr = 10'h025;
    smp(); chk("t2_ldrdy", ld_ready, 1); exp_q.push_back(32'hAABB_CCDD);
    cyc(); ld_addr = 10'h030;
    smp(); chk("t2_hold", {bram_we, ld_ready}, 2'b01); exp_q.push_back(pat(10'h030));
    cyc(); ld_valid = 0;
    smp();
    chk("t2_drain", {bram_we, bram_store, bram_hit_write, bram_waddr, bram_byte_ben},
        {1'b1, 1'b1, 1'b0, 10'h025, 4'hF});
    chk("t2_din", bram_din, 32'hAABB_CCDD);
    cyc(); ld_valid = 1; ld_addr = 10'h025;
    smp(); exp_q.push_back(32'hAABB_CCDD);
    cyc(); ld_valid = 0;

    // partial forward
    st_valid = 1; st_addr = 10'h026; st_wdata = 32'h0000_BEEF; st_ben = 4'h3;
    smp(); chk("t3_strdy", st_ready, 1);
    cyc(); st_valid = 0; ld_valid = 1; ld_addr = 10'h026;
    smp(); chk("t3_ldrdy", ld_ready, 1); exp_q.push_back(32'h1234_BEEF);
    cyc(); ld_valid = 0;
    smp();
    chk("t3_drain", {bram_we, bram_store, bram_waddr, bram_byte_ben},
        {1'b1, 1'b1, 10'h026, 4'h3});
    cyc(); ld_valid = 1; ld_addr = 10'h026;
    smp(); exp_q.push_back(32'h1234_BEEF);
    cyc(); ld_valid = 0;

    // starvation guard
    st_valid = 1; st_addr = 10'h040; st_wdata = 32'hCAFE_F00D; st_ben = 4'hF;
    smp();
    cyc(); st_valid = 0;
    for (int k = 0; k < 6; k++) begin
      ld_valid = 1;
      ld_addr = (k == 2) ? 10'h040 : 10'(10'h050 + k);
      smp();
      chk("t4_rdy", ld_ready, (k != 4));
      if (k == 4)
        chk("t4_force", {bram_we, bram_store, bram_re, bram_waddr},
            {1'b1, 1'b1, 1'b0, 10'h040});
      else
        exp_q.push_back((k == 2) ? 32'hCAFE_F00D : pat(int'(ld_addr)));
      cyc();
    end
    ld_addr = 10'h040;
    smp(); exp_q.push_back(32'hCAFE_F00D);
    cyc(); ld_valid = 0;

    // refill priority, store drains after and wins
    st_valid = 1; st_addr = 10'h049; st_wdata = 32'h7777_8888; st_ben = 4'hF;
    smp();
    cyc(); st_valid = 0;
    rf_valid = 1; rf_addr = 10'h048; ld_valid = 1; ld_addr = 10'h060;
    smp();
    chk("t5_rf", {bram_we, bram_hit_write, bram_store, bram_re, rf_ready, ld_ready},
        6'b110010);
    chk("t5_waddr", bram_waddr, 10'h048);
    chk("t5_line_lo", bram_din_all[63:0], 64'hF000_0001_F000_0000);
    chk("t5_line_hi", bram_din_all[255:192], 64'hF000_0007_F000_0006);
    cyc(); rf_valid = 0;
    smp(); chk("t5_ld", ld_ready, 1); exp_q.push_back(pat(10'h060));
    cyc(); ld_valid = 0;
    smp(); chk("t5_drain", {bram_we, bram_store, bram_waddr}, {1'b1, 1'b1, 10'h049});
    cyc(); ld_valid = 1; ld_addr = 10'h049;
    smp(); exp_q.push_back(32'h7777_8888);
    cyc(); ld_addr = 10'h04A;
    smp(); exp_q.push_back(32'hF000_0002);
    cyc(); ld_valid = 0;

    // accept while draining
    st_valid = 1; st_addr = 10'h030; st_wdata = 32'h3030_3030; st_ben = 4'hF;
    smp();
    cyc(); st_addr = 10'h031; st_wdata = 32'h3131_3131;
    smp();
    chk("t6_accept", {st_ready, bram_store, bram_waddr}, {1'b1, 1'b1, 10'h030});
    cyc(); st_valid = 0; ld_valid = 1; ld_addr = 10'h070;
    smp(); chk("t6_full", st_ready, 0); exp_q.push_back(pat(10'h070));
    cyc(); ld_valid = 0;
    smp();
    chk("t6_drain2", {bram_we, bram_store, bram_waddr}, {1'b1, 1'b1, 10'h031});
    chk("t6_din", bram_din, 32'h3131_3131);
    cyc(); ld_valid = 1; ld_addr = 10'h030;
    smp(); exp_q.push_back(32'h3030_3030);
    cyc(); ld_addr = 10'h031;
    smp(); exp_q.push_back(32'h3131_3131);
    cyc(); ld_valid = 0;

    repeat (3) cyc();
    chk("q_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
